spi_rx_slave: RTL
=================

Name: spi_rx_slave

Overview:
- SPI receiving end that pairs with the team's SPI master transmitter. It sits on the far side of the cs/sclk/mosi link.
- Oversamples the link in the local clk domain and deserializes mosi MSB-first into DATA_W-bit words.
- Presents each word on a valid/ready handshake and flags overrun and aborted frames.
- Supports multiple back-to-back words within one cs-low frame.

Parameters:
- DATA_W, 8: word width in bits. Bit counter width is $clog2(DATA_W+1).
- SYNC_STAGES, 2: synchronizer depth for sclk, cs and mosi. Minimum 2.

Ports:
- clk, input, 1: system clock. Must be at least 6x the sclk frequency.
- rst, input, 1: reset, synchronous, active-low.
- sclk, input, 1: SPI serial clock, asynchronous to clk.
- cs, input, 1: chip select, active-low, asynchronous.
- mosi, input, 1: serial data, launched by the master on sclk rising edge.
- rx_data, output, DATA_W: received word. Stable while rx_valid=1.
- rx_valid, output, 1: word available. Held until accepted.
- rx_ready, input, 1: consumer accept. A transfer occurs when rx_valid && rx_ready.
- overrun, output, 1: sticky. Set when a word completes while rx_valid=1. Cleared only by reset.
- frame_err, output, 1: one-cycle pulse when cs rises with 0 < bit_cnt < DATA_W.
- busy, output, 1: high while state is SHIFT.

Behaviour:
- Reset (rst=0 at posedge clk): rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, shift register=0, bit_cnt=0, state=IDLE.
  - Synchronizer flops reset to sclk=0, cs=1, mosi=0.
  - Reset mid-frame discards partial data and gives no frame_err.
- Synchronization and edge detection:
  - sclk, cs and mosi each pass through SYNC_STAGES flops, plus one history flop on sclk and cs.
  - sclk_fall = prev & ~cur; cs_fall and cs_rise are defined the same way.
- Sampling: mosi_s is shifted in on each sclk_fall while cs_s=0, MSB first: shreg <= {shreg[DATA_W-2:0], mosi_s}.
- State machine:
  - IDLE: busy=0, bit_cnt=0. On cs_fall, go to SHIFT.
  - SHIFT: busy=1.
    - On sclk_fall, bit_cnt increments.
    - When the increment reaches DATA_W: the word completes, bit_cnt resets to 0, and the state stays in SHIFT.
    - On cs_rise: go to IDLE. If 0 < bit_cnt < DATA_W, pulse frame_err and discard the partial word. bit_cnt is cleared.
  - Simultaneous sclk_fall and cs_rise in the same cycle: the sample is taken first, then the cs_rise rules are evaluated on the updated bit_cnt. A word completing in that cycle is delivered.
- Word completion, in the cycle after the final sclk_fall is detected:
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: rx_data <= completed word, rx_valid <= 1.
  - Otherwise: overrun <= 1, the new word is dropped, and rx_data/rx_valid are unchanged.
- Handshake:
  - rx_valid deasserts the cycle after rx_valid && rx_ready, unless a new word loads in that same cycle.
  - rx_ready is ignored while rx_valid=0.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the final falling sclk edge at the pin.
- sclk edges while cs_s=1 are ignored. A cs glitch shorter than one clk cycle is not guaranteed to be seen.

Optional Feature:
- Macro: SPI_RX_DAISY_EN.
- When defined:
  - Adds output miso (1 bit) for daisy-chaining.
  - The bit shifted out of shreg[DATA_W-1] is registered on each sclk_fall and driven on miso, so a downstream slave sees this slave's stream delayed by DATA_W bits.
  - miso=0 at reset and while cs_s=1.
- When not defined: no miso port and no extra logic.

Decomposition:
- Package spi_pkg: typedef enum logic [0:0] {RX_IDLE, RX_SHIFT} spi_rx_state_t; localparam SPI_DATA_W_DEFAULT = 8. The team's transmitter state enum also moves here.
- Sub-module spi_sync_edge: parameter SYNC_STAGES, inputs clk/rst/async_in, outputs sync_out, rise and fall. Instantiated once each for sclk, cs and mosi (edge outputs unused for mosi).

Test Plan:
- Single frame: cs low, 8 bits 0xAA, cs high, rx_ready=1 → exactly one rx_valid with rx_data=0xAA. frame_err=0, overrun=0.
- Multi-word: one cs-low frame carrying 0x3C then 0xC3, with rx_ready=1 → two rx_valid pulses, in order 0x3C then 0xC3, and busy high throughout.
- Abort: cs rises after 5 bits of 0xFF → frame_err one-cycle pulse, no rx_valid. The next full frame 0x5A is received correctly.
- Overrun: rx_ready=0, two words 0x11 then 0x22 → rx_valid=1, rx_data=0x11, overrun=1. Raising rx_ready deasserts rx_valid the next cycle.
- Reset mid-frame: rst=0 after 3 bits, released, then a full frame 0x81 → only 0x81 is delivered, with no frame_err.
- Daisy (SPI_RX_DAISY_EN): send 0xA5 then 0x0F in one frame → miso carries 0x00 during the first 8 sclk cycles, then 0xA5, MSB first.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI types for the master transmitter and the receiving slave.
package spi_pkg;

  localparam int SPI_DATA_W_DEFAULT = 8;

  typedef enum logic [0:0] {RX_IDLE, RX_SHIFT} spi_rx_state_t;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT, TX_DONE} spi_tx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a history flop
// providing single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = ~hist & sync_out;
  assign fall     = hist & ~sync_out;

endmodule

// File: rtl/spi_rx_slave.sv
// SPI receiving slave: oversamples cs/sclk/mosi, deserializes MSB-first words
// and hands them out on a valid/ready port. Define SPI_RX_DAISY_EN for miso.
module spi_rx_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
`ifdef SPI_RX_DAISY_EN
  output logic              miso,
`endif
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [0:0]      ST_IDLE  = RX_IDLE;
  localparam logic [0:0]      ST_SHIFT = RX_SHIFT;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  logic [0:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done_now;
  logic             word_done_p0;
  logic             load;
  logic [DATA_W-1:0] shreg;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .async_in(sclk),
    .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .async_in(cs),
    .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .async_in(mosi),
    .sync_out(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = &{1'b0, sclk_s, sclk_rise, mosi_rise, mosi_fall};

  // Bit count after this cycle's sample; wraps at a word boundary.
  always_comb begin
    cnt_next = bit_cnt;
    done_now = 1'b0;
    if (sclk_fall) begin
      if (bit_cnt == CNT_LAST) begin
        cnt_next = '0;
        done_now = 1'b1;
      end else begin
        cnt_next = bit_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (state == ST_SHIFT);
  assign load = word_done_p0 & (~rx_valid | rx_ready);

  // Stage p0: sample/count; a cs_rise sees the count after this cycle's sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      word_done_p0 <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      word_done_p0 <= 1'b0;
      frame_err    <= 1'b0;
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
        if (cs_fall) state <= ST_SHIFT;
      end else begin
        word_done_p0 <= done_now;
        if (cs_rise) begin
          state     <= ST_IDLE;
          bit_cnt   <= '0;
          frame_err <= (cnt_next != '0);
        end else begin
          bit_cnt <= cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= '0;
    end else if (state == ST_IDLE) begin
      shreg <= '0;
    end else if (sclk_fall) begin
      shreg <= {shreg[DATA_W-2:0], mosi_s};
    end
  end

  // Stage p1: hand the completed word to the consumer or flag the drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (load) begin
        rx_valid <= 1'b1;
        rx_data  <= shreg;
      end else if (word_done_p0) begin
        overrun <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_RX_DAISY_EN
  always_ff @(posedge clk) begin
    if (!rst || cs_s) begin
      miso <= 1'b0;
    end else if (state == ST_SHIFT && sclk_fall) begin
      miso <= shreg[DATA_W-1];
    end
  end
`endif

endmodule
